prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that writes 18-bit instruction words into the writable 1024x18 program memory. It is the fill side of the instruction store, which the MCU fetch path reads. It receives a framed byte stream from the UART receiver, assembles words, and issues one write per word. It holds the CPU in reset for the duration of a load and reports completion or checksum failure.

## Interface
- ADDR_W, 10, program memory address width (word count up to 2^ADDR_W)
- DATA_W, 18, instruction width; fixed at 18 by the byte packing below
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- RX_DATA  in  8  incoming byte
- RX_VALID  in  1  RX_DATA valid this cycle
- RX_READY  out  1  loader accepts byte this cycle (transfer = RX_VALID & RX_READY)
- WR_EN  out  1  program memory write strobe, one cycle per word
- WR_ADDR  out  ADDR_W  write address
- WR_DATA  out  DATA_W  write data
- CPU_HOLD  out  1  held high while a frame is in progress; drives the MCU reset
- DONE  out  1  sticky: last frame loaded and checksum matched
- ERR  out  1  sticky: last frame failed checksum

## Operation
- Frame format: sync 0xA5, CNT_HI, CNT_LO, N words of 3 bytes each, then CHK.
- Count field is {CNT_HI[1:0], CNT_LO} = N-1, giving 1..1024 words. CNT_HI[7:2] is ignored.
- Word packing: byte order B0, B1, B2; word = {B0[1:0], B1, B2}. B0[7:2] is ignored.
- CHK = 8-bit modulo-256 sum of every byte after sync: CNT_HI, CNT_LO and all word bytes.
- Words are written to consecutive addresses starting at 0.
- States and transitions:
  - IDLE: discard non-0xA5 bytes. On 0xA5 go to CNT_HI, set CPU_HOLD, clear DONE and ERR, clear the sum.
  - CNT_HI, CNT_LO: latch the count, add each byte to the sum. Then go to B0; word index = 0.
  - B0, B1, B2: assemble the word and add each byte to the sum. After B2 go to WRITE.
  - WRITE: one cycle. WR_EN=1, WR_ADDR=index, WR_DATA=assembled word, RX_READY=0. If index==N-1 go to CHK; else index+1 and go to B0.
  - CHK: compare the received byte with the sum.
    - Match: DONE=1, CPU_HOLD=0, go to IDLE.
    - Mismatch: ERR=1, CPU_HOLD=0, go to IDLE.
- RX_READY=1 in IDLE, CNT_HI, CNT_LO, B0, B1, B2 and CHK. RX_READY=0 in WRITE and while RST=1.
- 0xA5 inside a frame is ordinary data, not a resync.
- Words written before a checksum failure stay written. Memory content after ERR is undefined.
- WR_ADDR and WR_DATA hold their last value when WR_EN=0.

## Timing
- Reset values (registered): state IDLE, WR_EN=0, WR_ADDR=0, WR_DATA=0, CPU_HOLD=0, DONE=0, ERR=0, index=0, sum=0. RX_READY=0 while RST=1.
- RST asserted mid-frame:
  - Next edge returns to IDLE with all reset values.
  - A pending WRITE is not issued.
  - CPU_HOLD drops.
- CPU_HOLD rises the cycle after sync is accepted. It falls the cycle after CHK is accepted.
- DONE/ERR rise on that same edge as CPU_HOLD falls, and stay high until the next accepted sync.
- WR_EN pulses exactly one cycle, in the cycle after B2 is accepted.
- Minimum frame duration with RX_VALID held high: 1 + 2 + 4N + 1 cycles.
- Stalls: RX_VALID low in any state holds the state. No timeout.
- Index wrap: N=1024 ends at index 1023, with no wrap past it.
- CNT=0 means N=1: exactly one write.

## Test plan
- Basic load: stream A5 00 01 03 FF FF 00 12 34 48 back-to-back.
  - Writes: addr 0 = 0x3FFFF, addr 1 = 0x01234.
  - DONE=1, ERR=0, CPU_HOLD high from cycle 2 through the CHK cycle.
- Bad checksum: same frame with CHK=0x49.
  - Both writes occur; ERR=1, DONE=0, CPU_HOLD=0 afterwards.
- Garbage and stalls:
  - Precede the frame with 00 FF 5A, and insert random RX_VALID gaps.
  - No writes before sync; identical result to the basic load.
  - RX_READY=0 during each WRITE cycle, and no byte is lost.
- Full depth: CNT=03 FF, 1024 words with word i = i*3 mod 2^18, correct CHK.
  - 1024 writes at addresses 0..1023 with no wrap, then DONE=1.
- Reset mid-frame: assert RST after B1 of word 5.
  - No further WR_EN; outputs return to reset values.
  - A following complete frame loads normally.
- Back-to-back frames: a good frame, then a frame with a bad CHK.
  - DONE clears on the second sync; ERR=1 at the end.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses sync/count/words/checksum frames and
// writes assembled 18-bit words into program memory while holding the CPU.
module prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_B0     = 3'd3,
        S_B1     = 3'd4,
        S_B2     = 3'd5,
        S_WRITE  = 3'd6,
        S_CHK    = 3'd7
    } state_t;

    function automatic logic [7:0] sum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          cnt_hi_r, cnt_hi_s;
    logic [ADDR_W-1:0]   cnt_r, cnt_s;
    logic [ADDR_W-1:0]   idx_r, idx_s;
    logic [7:0]          sum_r, sum_s;
    logic [1:0]          b0_r, b0_s;
    logic [7:0]          b1_r, b1_s;
    logic                wr_en_r, wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0]   wr_data_r, wr_data_s;
    logic                hold_r, hold_s;
    logic                done_r, done_s;
    logic                err_r, err_s;
    logic                accept_s;

    assign RX_READY = !RST && (state_r != S_WRITE);
    assign WR_EN    = wr_en_r;
    assign WR_ADDR  = wr_addr_r;
    assign WR_DATA  = wr_data_r;
    assign CPU_HOLD = hold_r;
    assign DONE     = done_r;
    assign ERR      = err_r;

    // Next-state and next-output computation for the frame parser.
    always_comb begin
        state_s   = state_r;
        cnt_hi_s  = cnt_hi_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        sum_s     = sum_r;
        b0_s      = b0_r;
        b1_s      = b1_r;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        hold_s    = hold_r;
        done_s    = done_r;
        err_s     = err_r;
        accept_s  = RX_VALID && (state_r != S_WRITE);

        if (state_r == S_WRITE) begin
            // WRITE advances without a byte; it only decides the next word or CHK.
            if (idx_r == cnt_r) begin
                state_s = S_CHK;
            end else begin
                idx_s   = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                state_s = S_B0;
            end
        end else if (accept_s) begin
            case (state_r)
                S_IDLE: begin
                    if (RX_DATA == 8'hA5) begin
                        state_s = S_CNT_HI;
                        hold_s  = 1'b1;
                        done_s  = 1'b0;
                        err_s   = 1'b0;
                        sum_s   = 8'h00;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_CNT_HI: begin
                    cnt_hi_s = RX_DATA[1:0];
                    sum_s    = sum_add(sum_r, RX_DATA);
                    state_s  = S_CNT_LO;
                end
                S_CNT_LO: begin
                    cnt_s   = ADDR_W'({cnt_hi_r, RX_DATA});
                    sum_s   = sum_add(sum_r, RX_DATA);
                    idx_s   = {ADDR_W{1'b0}};
                    state_s = S_B0;
                end
                S_B0: begin
                    b0_s    = RX_DATA[1:0];
                    sum_s   = sum_add(sum_r, RX_DATA);
                    state_s = S_B1;
                end
                S_B1: begin
                    b1_s    = RX_DATA;
                    sum_s   = sum_add(sum_r, RX_DATA);
                    state_s = S_B2;
                end
                S_B2: begin
                    sum_s     = sum_add(sum_r, RX_DATA);
                    wr_en_s   = 1'b1;
                    wr_addr_s = idx_r;
                    wr_data_s = DATA_W'({b0_r, b1_r, RX_DATA});
                    state_s   = S_WRITE;
                end
                S_CHK: begin
                    hold_s  = 1'b0;
                    state_s = S_IDLE;
                    if (RX_DATA == sum_r) begin
                        done_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= S_IDLE;
            cnt_hi_r  <= 2'd0;
            cnt_r     <= {ADDR_W{1'b0}};
            idx_r     <= {ADDR_W{1'b0}};
            sum_r     <= 8'h00;
            b0_r      <= 2'd0;
            b1_r      <= 8'h00;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
            hold_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_hi_r  <= cnt_hi_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            sum_r     <= sum_s;
            b0_r      <= b0_s;
            b1_r      <= b1_s;
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            hold_r    <= hold_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: a frame model predicts the
// memory writes and status flags, a monitor checks every WR_EN pulse.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        WR_EN;
    logic [9:0]  WR_ADDR;
    logic [17:0] WR_DATA;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;

    prog_loader #(.ADDR_W(10), .DATA_W(18)) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0]  addr;
        logic [17:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  fq[$];
    logic [17:0] words[1024];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each write pulse must match the next predicted word
    always @(negedge CLK) begin
        if (WR_EN === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", WR_ADDR, WR_DATA);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(WR_ADDR), 32'(e.addr));
                check("wr_data", 32'(WR_DATA), 32'(e.data));
                check("ready_in_write", 32'(RX_READY), 32'd0);
                check("hold_in_write", 32'(CPU_HOLD), 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        int t;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        RX_VALID = 1'b0;
        repeat (g) @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        t = 0;
        while (RX_READY !== 1'b1 && t < 10) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 10) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got RX_READY=%b after %0d cycles, expected 1", RX_READY, t);
        end
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    // Model of a frame: bytes from the word list, checksum as a plain byte sum
    task automatic build_frame(input int n, input bit bad);
        logic [9:0] c;
        logic [7:0] sum;
        logic [7:0] b;
        fq.delete();
        c = 10'(n - 1);
        sum = 8'h00;
        fq.push_back(8'hA5);
        b = {6'($urandom), c[9:8]}; fq.push_back(b); sum = sum + b;
        b = c[7:0];                 fq.push_back(b); sum = sum + b;
        for (int i = 0; i < n; i++) begin
            b = {6'($urandom), words[i][17:16]}; fq.push_back(b); sum = sum + b;
            b = words[i][15:8];                  fq.push_back(b); sum = sum + b;
            b = words[i][7:0];                   fq.push_back(b); sum = sum + b;
        end
        if (bad) sum = sum + 8'($urandom_range(1, 255));
        fq.push_back(sum);
    endtask

    task automatic push_expected(input int k);
        wr_t e;
        for (int i = 0; i < k; i++) begin
            e.addr = 10'(i);
            e.data = words[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic run_fq(input bit bad, input int maxgap);
        send_byte(fq[0], maxgap);
        check("hold_after_sync", 32'(CPU_HOLD), 32'd1);
        check("done_after_sync", 32'(DONE), 32'd0);
        check("err_after_sync", 32'(ERR), 32'd0);
        for (int i = 1; i < fq.size() - 1; i++) send_byte(fq[i], maxgap);
        check("hold_before_chk", 32'(CPU_HOLD), 32'd1);
        send_byte(fq[fq.size() - 1], maxgap);
        check("hold_after_chk", 32'(CPU_HOLD), 32'd0);
        check("done", 32'(DONE), bad ? 32'd0 : 32'd1);
        check("err", 32'(ERR), bad ? 32'd1 : 32'd0);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input int n, input bit bad, input int maxgap);
        build_frame(n, bad);
        push_expected(n);
        run_fq(bad, maxgap);
    endtask

    task automatic load_basic(input logic [7:0] chk);
        logic [7:0] lit [10];
        lit = '{8'hA5, 8'h00, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h48};
        fq.delete();
        for (int i = 0; i < 10; i++) fq.push_back(lit[i]);
        fq[9] = chk;
        words[0] = 18'h3FFFF;
        words[1] = 18'h01234;
        push_expected(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA = 8'h00;
        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(RX_READY), 32'd0);
        check("rst_wr_en", 32'(WR_EN), 32'd0);
        check("rst_hold", 32'(CPU_HOLD), 32'd0);
        check("rst_done_err", 32'({DONE, ERR}), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_ready", 32'(RX_READY), 32'd1);

        // basic load, then the same frame with a bad checksum
        load_basic(8'h48);
        run_fq(1'b0, 0);
        load_basic(8'h49);
        run_fq(1'b1, 0);

        // garbage before sync and random valid gaps
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        send_byte(8'h5A, 3);
        check("garbage_hold", 32'(CPU_HOLD), 32'd0);
        load_basic(8'h48);
        run_fq(1'b0, 3);

        // full depth
        for (int i = 0; i < 1024; i++) words[i] = 18'(i * 3);
        run_frame(1024, 1'b0, 0);

        // reset after B1 of word 5
        for (int i = 0; i < 8; i++) words[i] = 18'($urandom);
        build_frame(8, 1'b0);
        push_expected(5);
        for (int i = 0; i < 20; i++) send_byte(fq[i], 0);
        RST = 1'b1;
        #1;
        check("rst_mid_ready", 32'(RX_READY), 32'd0);
        @(negedge CLK);
        check("rst_mid_wr_en", 32'(WR_EN), 32'd0);
        check("rst_mid_addr", 32'(WR_ADDR), 32'd0);
        check("rst_mid_data", 32'(WR_DATA), 32'd0);
        check("rst_mid_hold", 32'(CPU_HOLD), 32'd0);
        check("rst_mid_done_err", 32'({DONE, ERR}), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_mid_pending", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) words[i] = 18'($urandom);
        run_frame(3, 1'b0, 2);

        // back-to-back: good then bad
        for (int i = 0; i < 5; i++) words[i] = 18'($urandom);
        run_frame(4, 1'b0, 0);
        run_frame(5, 1'b1, 0);

        // random frames
        repeat (8) begin
            int n;
            n = int'($urandom_range(1, 40));
            for (int i = 0; i < n; i++) words[i] = 18'($urandom);
            run_frame(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
